// File: rtl/disp_value_ctrl_pkg.sv
// rtl/disp_value_ctrl_pkg.sv - shared constants, action type and helpers for disp_value_ctrl
// Purpose: debounce default, step constants, reset values, step and blanking helpers.
// Ports: none (package).
package disp_value_ctrl_pkg;

   localparam int          DEB_CYCLES_DEF = 1000000;

   localparam logic [31:0] STEP_0 = 32'h0000_0001;
   localparam logic [31:0] STEP_1 = 32'h0000_0010;
   localparam logic [31:0] STEP_2 = 32'h0000_0100;
   localparam logic [31:0] STEP_3 = 32'h0000_1000;

   localparam logic [31:0] VALUE_RST    = 32'h0000_0000;
   localparam logic [7:0]  DIGIT_EN_RST = 8'h01;

   typedef enum logic [1:0] {
      ACT_NONE = 2'd0,
      ACT_CLR  = 2'd1,
      ACT_UP   = 2'd2,
      ACT_DOWN = 2'd3
   } action_t;

   function automatic logic [31:0] step_of(input logic [1:0] sel);
      logic [31:0] s;
      case (sel)
         2'd0:    s = STEP_0;
         2'd1:    s = STEP_1;
         2'd2:    s = STEP_2;
         default: s = STEP_3;
      endcase
      return s;
   endfunction

   // Leading-zero blanking: digit i lit when it or any more significant
   // nibble is nonzero; the least significant digit is always lit.
   function automatic logic [7:0] digit_mask(input logic [31:0] v);
      logic [7:0] m;
      m[0] = 1'b1;
      for (int i = 1; i < 8; i++) begin
         m[i] = ((v >> (4 * i)) != 32'd0);
      end
      return m;
   endfunction

endpackage

// File: rtl/disp_value_ctrl_btn_debounce.sv
// rtl/disp_value_ctrl_btn_debounce.sv - synchronizer, debounce counter and press pulse for one button
// Purpose: turns a raw asynchronous push-button into a one-cycle press pulse.
// Ports:
//   clock  - system clock, rising edge
//   reset  - synchronous active-high reset
//   btn    - raw asynchronous button level
//   press  - registered one-cycle pulse on an accepted 0->1 transition
module btn_debounce
   import disp_value_ctrl_pkg::*;
#(
   parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
   input  logic clock,
   input  logic reset,
   input  logic btn,
   output logic press
);

   localparam int CW = $clog2(DEB_CYCLES + 1);

   logic          sync1;
   logic          sync2;
   logic          deb;
   logic          deb_d;
   logic [CW-1:0] cnt;

   always_ff @(posedge clock) begin
      if (reset) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         deb   <= 1'b0;
         deb_d <= 1'b0;
         cnt   <= '0;
         press <= 1'b0;
      end else begin
         sync1 <= btn;
         sync2 <= sync1;
         // Any agreeing cycle restarts the count; the level flips only once
         // the count has reached DEB_CYCLES and the input still disagrees.
         if (sync2 == deb) begin
            cnt <= '0;
         end else if (cnt == CW'(DEB_CYCLES)) begin
            deb <= ~deb;
            cnt <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
         deb_d <= deb;
         press <= deb & ~deb_d;
      end
   end

endmodule

// File: rtl/disp_value_ctrl.sv
// rtl/disp_value_ctrl.sv - button-driven 32-bit hex value with leading-zero digit blanking
// Purpose: debounced up/down/clear buttons adjust a value by a selectable hex step.
// Ports:
//   clock    - system clock, rising edge
//   reset    - synchronous active-high reset
//   btn_up   - raw button, increment
//   btn_down - raw button, decrement
//   btn_clr  - raw button, clear
//   step_sel - step = 1 << (4*step_sel)
//   value    - registered 8-hex-digit value
//   digit_en - registered per-digit enable, 0 blanks that digit
//   update   - one-cycle pulse in the first cycle a new value is visible
module disp_value_ctrl
   import disp_value_ctrl_pkg::*;
#(
   parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        btn_up,
   input  logic        btn_down,
   input  logic        btn_clr,
   input  logic [1:0]  step_sel,
   output logic [31:0] value,
   output logic [7:0]  digit_en,
   output logic        update
);

   logic    up_p;
   logic    down_p;
   logic    clr_p;
   action_t act;
   logic [31:0] next_value;

   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
      .clock (clock),
      .reset (reset),
      .btn   (btn_up),
      .press (up_p)
   );

   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_down (
      .clock (clock),
      .reset (reset),
      .btn   (btn_down),
      .press (down_p)
   );

   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clr (
      .clock (clock),
      .reset (reset),
      .btn   (btn_clr),
      .press (clr_p)
   );

   // Clear dominates; simultaneous up and down cancel out.
   always_comb begin
      act        = ACT_NONE;
      next_value = value;
      if (clr_p) begin
         act        = ACT_CLR;
         next_value = 32'd0;
      end else if (up_p && down_p) begin
         act        = ACT_NONE;
      end else if (up_p) begin
         act        = ACT_UP;
         next_value = value + step_of(step_sel);
      end else if (down_p) begin
         act        = ACT_DOWN;
         next_value = value - step_of(step_sel);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         value    <= VALUE_RST;
         digit_en <= DIGIT_EN_RST;
         update   <= 1'b0;
      end else begin
         update <= (act != ACT_NONE);
         if (act != ACT_NONE) begin
            value    <= next_value;
            digit_en <= digit_mask(next_value);
         end
      end
   end

endmodule

// File: tb/tb_disp_value_ctrl.sv
// tb/tb_disp_value_ctrl.sv - directed self-checking bench for disp_value_ctrl
module tb_disp_value_ctrl;

   logic        clock;
   logic        reset;
   logic        btn_up;
   logic        btn_down;
   logic        btn_clr;
   logic [1:0]  step_sel;
   logic [31:0] value;
   logic [7:0]  digit_en;
   logic        update;

   int n_checks = 0;
   int n_errors = 0;
   int upd_cnt  = 0;
   int base;

   disp_value_ctrl #(.DEB_CYCLES(4)) dut (
      .clock    (clock),
      .reset    (reset),
      .btn_up   (btn_up),
      .btn_down (btn_down),
      .btn_clr  (btn_clr),
      .step_sel (step_sel),
      .value    (value),
      .digit_en (digit_en),
      .update   (update)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(negedge clock) begin
      if (update) upd_cnt <= upd_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   // mask bit 0 = up, 1 = down, 2 = clr; hold long enough to be accepted, then settle.
   task automatic press(input logic [2:0] mask, input logic [1:0] sel);
      @(posedge clock); #1;
      step_sel = sel;
      btn_up   = mask[0];
      btn_down = mask[1];
      btn_clr  = mask[2];
      cycles(20);
      btn_up   = 1'b0;
      btn_down = 1'b0;
      btn_clr  = 1'b0;
      cycles(20);
      @(negedge clock);
   endtask

   initial begin
      reset = 1'b1; btn_up = 1'b0; btn_down = 1'b0; btn_clr = 1'b0; step_sel = 2'd0;
      cycles(3);
      @(negedge clock);
      check("rst_value", value, 32'h0);
      check("rst_digit_en", {24'd0, digit_en}, 32'h01);
      check("rst_update", {31'd0, update}, 32'd0);
      @(posedge clock); #1;
      reset = 1'b0;

      // Exact latency: first sampled at edge k, change at edge k+8.
      base = upd_cnt;
      @(posedge clock); #1;
      btn_up = 1'b1;
      @(posedge clock);            // edge k
      repeat (7) @(posedge clock); // edge k+7
      @(negedge clock);
      check("lat_value_k7", value, 32'h0);
      check("lat_update_k7", {31'd0, update}, 32'd0);
      @(posedge clock);            // edge k+8
      @(negedge clock);
      check("lat_value_k8", value, 32'h1);
      check("lat_update_k8", {31'd0, update}, 32'd1);
      check("lat_digit_en", {24'd0, digit_en}, 32'h01);
      @(negedge clock);
      check("lat_update_k9", {31'd0, update}, 32'd0);
      cycles(12);
      btn_up = 1'b0;
      cycles(20);
      @(negedge clock);
      check("hold_one_pulse", upd_cnt - base, 32'd1);

      // Short glitch is ignored.
      base = upd_cnt;
      @(posedge clock); #1;
      btn_up = 1'b1;
      cycles(3);
      btn_up = 1'b0;
      cycles(20);
      @(negedge clock);
      check("glitch_updates", upd_cnt - base, 32'd0);
      check("glitch_value", value, 32'h1);

      // Clear, then clear again at zero still pulses.
      base = upd_cnt;
      press(3'b100, 2'd0);
      check("clr_value", value, 32'h0);
      check("clr_updates", upd_cnt - base, 32'd1);
      base = upd_cnt;
      press(3'b100, 2'd0);
      check("clr0_value", value, 32'h0);
      check("clr0_updates", upd_cnt - base, 32'd1);

      // Down wrap from zero.
      base = upd_cnt;
      press(3'b010, 2'd0);
      check("down_wrap_value", value, 32'hFFFF_FFFF);
      check("down_wrap_digit_en", {24'd0, digit_en}, 32'hFF);
      check("down_wrap_updates", upd_cnt - base, 32'd1);

      // Up wrap to zero.
      base = upd_cnt;
      press(3'b001, 2'd0);
      check("up_wrap_value", value, 32'h0);
      check("up_wrap_digit_en", {24'd0, digit_en}, 32'h01);
      check("up_wrap_updates", upd_cnt - base, 32'd1);

      // Reach 0xFFF: 0 - 1 = 0xFFFFFFFF, + 0x1000 = 0x00000FFF.
      press(3'b010, 2'd0);
      press(3'b001, 2'd3);
      check("fff_value", value, 32'h0000_0FFF);
      check("fff_digit_en", {24'd0, digit_en}, 32'h07);
      press(3'b001, 2'd3);
      check("step3_value", value, 32'h0000_1FFF);
      check("step3_digit_en", {24'd0, digit_en}, 32'h0F);

      // Up and down on the same edge cancel.
      base = upd_cnt;
      press(3'b011, 2'd0);
      check("updown_value", value, 32'h0000_1FFF);
      check("updown_updates", upd_cnt - base, 32'd0);

      // Build 0x12 then clear with up held simultaneously.
      press(3'b100, 2'd0);
      press(3'b001, 2'd1);
      check("step1_value", value, 32'h10);
      check("step1_digit_en", {24'd0, digit_en}, 32'h03);
      press(3'b001, 2'd0);
      press(3'b001, 2'd0);
      check("v12_value", value, 32'h12);
      base = upd_cnt;
      press(3'b101, 2'd0);
      check("clrup_value", value, 32'h0);
      check("clrup_updates", upd_cnt - base, 32'd1);

      // Down with step 2 from zero.
      press(3'b010, 2'd2);
      check("down_step2_value", value, 32'hFFFF_FF00);

      // Reset mid-press discards the event; the still-held button is a new press.
      press(3'b100, 2'd0);
      @(posedge clock); #1;
      btn_up = 1'b1;
      cycles(5);
      reset = 1'b1;
      cycles(2);
      reset = 1'b0;
      base = upd_cnt;
      @(negedge clock);
      check("midrst_value", value, 32'h0);
      @(posedge clock);            // edge k after reset release
      repeat (7) @(posedge clock);
      @(negedge clock);
      check("midrst_value_k7", value, 32'h0);
      @(posedge clock);
      @(negedge clock);
      check("midrst_value_k8", value, 32'h1);
      check("midrst_update_k8", {31'd0, update}, 32'd1);
      btn_up = 1'b0;
      cycles(20);
      @(negedge clock);
      check("midrst_updates", upd_cnt - base, 32'd1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/disp_value_ctrl.md
DISP_VALUE_CTRL -- requirements
Module: disp_value_ctrl

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 1000000, meaning consecutive stable cycles required to accept a button level change (10 ms at 100 MHz).
REQ-002 SHALL have port clock  input  1  single system clock; all logic on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port btn_up  input  1  raw asynchronous push-button, increment.
REQ-005 SHALL have port btn_down  input  1  raw asynchronous push-button, decrement.
REQ-006 SHALL have port btn_clr  input  1  raw asynchronous push-button, clear.
REQ-007 SHALL have port step_sel  input  2  step size select, sampled when an action is applied.
REQ-008 SHALL have port value  output  32  registered 8-hex-digit value feeding the display stage's digit/cathode path.
REQ-009 SHALL have port digit_en  output  8  registered per-digit enable (bit i = hex digit i); 0 = blank that anode.
REQ-010 SHALL have port update  output  1  one-cycle pulse, high in the first cycle a new value is visible.

Function
REQ-011 Each raw button SHALL pass a 2-flop synchronizer before any other use.
REQ-012 Debounce: counter SHALL increment each cycle the synchronized level differs from the debounced level, clear on any agreeing cycle, and flip the debounced level when DEB_CYCLES consecutive differing cycles are reached.
REQ-013 A press pulse SHALL be a registered one-cycle pulse on a debounced 0->1 transition only; release produces no action; a held button produces exactly one pulse.
REQ-014 Step SHALL be 1 << (4*step_sel): 0x1, 0x10, 0x100, 0x1000.
REQ-015 Priority per cycle: clr pulse -> value = 0; else up and down pulses together -> no change, no update; else up -> value + step; else down -> value - step.
REQ-016 Arithmetic SHALL be modulo 2^32: 0xFFFFFFFF + 1 = 0x00000000; 0x00000000 - 1 = 0xFFFFFFFF.
REQ-017 Latency: raw button first sampled high at edge k and held -> value/update change at edge k + DEB_CYCLES + 4, exactly.
REQ-018 update SHALL pulse on every applied action, including clr when value was already 0 and up/down producing a wrap.
REQ-019 digit_en[0] SHALL always be 1; digit_en[i], i>0, SHALL be 1 iff any of nibbles i..7 of the new value is nonzero (leading-zero blanking), registered in the same cycle as value.
REQ-020 Glitches shorter than DEB_CYCLES cycles SHALL produce no pulse and no value change.

Reset
REQ-021 On reset: value = 0x00000000, digit_en = 0x01, update = 0, debounced levels = 0, debounce counters = 0, synchronizers = 0.
REQ-022 Reset mid-debounce or mid-press SHALL discard the pending event; a button still held after reset deasserts SHALL be treated as a new press after the full REQ-017 latency.

Structure
REQ-023 Shared package SHALL hold the DEB_CYCLES default, the four step constants, and the reset values of value and digit_en.
REQ-024 One sub-module btn_debounce (synchronizer + debounce counter + press pulse) SHALL be instantiated three times; counter width = clog2(DEB_CYCLES+1).
REQ-025 Action/priority logic, value register and blanking logic SHALL reside in disp_value_ctrl.

Verification (DEB_CYCLES = 4)
REQ-026 Reset asserted 3 cycles -> value 0x00000000, digit_en 0x01, update 0.
REQ-027 btn_up high 20 cycles, step_sel 0 -> value 0x00000001 at edge k+8, single update pulse, digit_en 0x01.
REQ-028 btn_up high 3 cycles then low -> no update, value unchanged.
REQ-029 value 0, btn_down press -> value 0xFFFFFFFF, digit_en 0xFF, one update.
REQ-030 value 0x00000FFF, step_sel 3, btn_up press -> value 0x00001FFF, digit_en 0x0F.
REQ-031 btn_up and btn_down same edge -> no change, no update; btn_clr with btn_up from 0x12 -> value 0, update 1.
